// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the four-way light bus.
// Decodes the N/S/E/W light codes into the active direction and phase, then
// flags illegal codes, conflicting greens, out-of-order phases and wrong run
// lengths. Every output is registered, so it reflects the previous sample.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   N/S/E/W_light[2:0]  light codes: 001 green, 010 yellow, 100 red
//   clr_err             clears err_sticky and err_count
//   active_dir[1:0]     decoded non-red direction (0 N, 1 W, 2 S, 3 E)
//   phase               0 green, 1 yellow
//   locked              monitor is synchronised to the light sequence
//   err_code            pulse: illegal code or all directions red
//   err_conflict        pulse: two or more directions non-red
//   err_order           pulse: illegal phase transition
//   err_timing          pulse: wrong run length
//   err_sticky          set by any error
//   err_count[7:0]      number of error cycles, saturating at 255
module traffic_light_monitor #(
   parameter int unsigned GREEN_CYCLES  = 16,
   parameter int unsigned YELLOW_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] N_light,
   input  logic [2:0] S_light,
   input  logic [2:0] E_light,
   input  logic [2:0] W_light,
   input  logic       clr_err,
   output logic [1:0] active_dir,
   output logic       phase,
   output logic       locked,
   output logic       err_code,
   output logic       err_conflict,
   output logic       err_order,
   output logic       err_timing,
   output logic       err_sticky,
   output logic [7:0] err_count
);

   localparam logic [2:0] CODE_GREEN  = 3'b001;
   localparam logic [2:0] CODE_YELLOW = 3'b010;
   localparam logic [2:0] CODE_RED    = 3'b100;
   localparam logic [7:0] GREEN_LEN   = 8'(GREEN_CYCLES);
   localparam logic [7:0] YELLOW_LEN  = 8'(YELLOW_CYCLES);
   localparam logic [7:0] CNT_MAX     = 8'hFF;

   typedef enum logic {SYNC, LOCKED} state_t;

   state_t     state_q, state_d;
   logic [7:0] run_len_q, run_len_d;
   logic [1:0] prev_dir_q, prev_dir_d;
   logic       prev_phase_q, prev_phase_d;
   logic       prev_valid_q, prev_valid_d;
   logic       overstay_q, overstay_d;
   logic [1:0] active_dir_q, active_dir_d;
   logic       phase_q, phase_d;
   logic       locked_q, locked_d;
   logic       err_code_q, err_code_d;
   logic       err_conflict_q, err_conflict_d;
   logic       err_order_q, err_order_d;
   logic       err_timing_q, err_timing_d;
   logic       err_sticky_q, err_sticky_d;
   logic [7:0] err_count_q, err_count_d;

   // Direction index order matches active_dir encoding: N, W, S, E
   logic [2:0] code_c [4];
   assign code_c[0] = N_light;
   assign code_c[1] = W_light;
   assign code_c[2] = S_light;
   assign code_c[3] = E_light;

   logic       illegal_c, all_red_c, valid_c;
   logic [2:0] nonred_cnt_c;
   logic [1:0] samp_dir_c;
   logic       samp_phase_c;

   // Per-sample decode
   always_comb begin
      illegal_c    = 1'b0;
      all_red_c    = 1'b1;
      nonred_cnt_c = 3'd0;
      samp_dir_c   = 2'd0;
      samp_phase_c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (code_c[i] != CODE_RED) all_red_c = 1'b0;
         if (code_c[i] != CODE_GREEN && code_c[i] != CODE_YELLOW && code_c[i] != CODE_RED) begin
            illegal_c = 1'b1;
         end else if (code_c[i] != CODE_RED) begin
            nonred_cnt_c = nonred_cnt_c + 3'd1;
            samp_dir_c   = 2'(i);
            samp_phase_c = (code_c[i] == CODE_YELLOW);
         end
      end
      valid_c = !illegal_c && (nonred_cnt_c == 3'd1);
   end

   logic [7:0] cur_len_c, prev_len_c;
   logic       same_c, legal_step_c, any_err_c;
   logic       sticky_base_c;
   logic [7:0] count_base_c;

   // Sequence tracking and error accounting
   always_comb begin
      state_d        = state_q;
      run_len_d      = run_len_q;
      prev_dir_d     = prev_dir_q;
      prev_phase_d   = prev_phase_q;
      prev_valid_d   = prev_valid_q;
      overstay_d     = overstay_q;
      active_dir_d   = active_dir_q;
      phase_d        = phase_q;
      locked_d       = locked_q;
      err_code_d     = illegal_c || all_red_c;
      err_conflict_d = (nonred_cnt_c >= 3'd2);
      err_order_d    = 1'b0;
      err_timing_d   = 1'b0;

      cur_len_c    = samp_phase_c ? YELLOW_LEN : GREEN_LEN;
      prev_len_c   = prev_phase_q ? YELLOW_LEN : GREEN_LEN;
      same_c       = (samp_dir_c == prev_dir_q) && (samp_phase_c == prev_phase_q);
      // green -> same-direction yellow, or yellow -> next-direction green
      legal_step_c = (!prev_phase_q && samp_phase_c && samp_dir_c == prev_dir_q) ||
                     (prev_phase_q && !samp_phase_c && samp_dir_c == 2'(prev_dir_q + 2'd1));

      if (!valid_c) begin
         prev_valid_d = 1'b0;
         locked_d     = 1'b0;
         state_d      = SYNC;
         run_len_d    = 8'd0;
      end else begin
         unique case (state_q)
            SYNC: begin
               if (prev_valid_q && !same_c) begin
                  state_d    = LOCKED;
                  locked_d   = 1'b1;
                  run_len_d  = 8'd1;
                  overstay_d = 1'b0;
               end
            end
            LOCKED: begin
               if (same_c) begin
                  if (run_len_q != CNT_MAX) run_len_d = run_len_q + 8'd1;
                  // run_len reaches E+1 on this sample
                  if (run_len_q == cur_len_c && run_len_q != CNT_MAX && !overstay_q) begin
                     err_timing_d = 1'b1;
                     overstay_d   = 1'b1;
                  end
               end else begin
                  err_order_d  = !legal_step_c;
                  err_timing_d = (run_len_q < prev_len_c);
                  run_len_d    = 8'd1;
                  overstay_d   = 1'b0;
               end
            end
            default: state_d = SYNC;
         endcase
         active_dir_d = samp_dir_c;
         phase_d      = samp_phase_c;
         prev_dir_d   = samp_dir_c;
         prev_phase_d = samp_phase_c;
         prev_valid_d = 1'b1;
      end

      // Clear happens first so an error in the same cycle still counts
      any_err_c     = err_code_d || err_conflict_d || err_order_d || err_timing_d;
      sticky_base_c = clr_err ? 1'b0 : err_sticky_q;
      count_base_c  = clr_err ? 8'd0 : err_count_q;
      err_sticky_d  = sticky_base_c || any_err_c;
      err_count_d   = count_base_c;
      if (any_err_c && count_base_c != CNT_MAX) err_count_d = count_base_c + 8'd1;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= SYNC;
         run_len_q      <= 8'd0;
         prev_dir_q     <= 2'd0;
         prev_phase_q   <= 1'b0;
         prev_valid_q   <= 1'b0;
         overstay_q     <= 1'b0;
         active_dir_q   <= 2'd0;
         phase_q        <= 1'b0;
         locked_q       <= 1'b0;
         err_code_q     <= 1'b0;
         err_conflict_q <= 1'b0;
         err_order_q    <= 1'b0;
         err_timing_q   <= 1'b0;
         err_sticky_q   <= 1'b0;
         err_count_q    <= 8'd0;
      end else begin
         state_q        <= state_d;
         run_len_q      <= run_len_d;
         prev_dir_q     <= prev_dir_d;
         prev_phase_q   <= prev_phase_d;
         prev_valid_q   <= prev_valid_d;
         overstay_q     <= overstay_d;
         active_dir_q   <= active_dir_d;
         phase_q        <= phase_d;
         locked_q       <= locked_d;
         err_code_q     <= err_code_d;
         err_conflict_q <= err_conflict_d;
         err_order_q    <= err_order_d;
         err_timing_q   <= err_timing_d;
         err_sticky_q   <= err_sticky_d;
         err_count_q    <= err_count_d;
      end
   end

   assign active_dir   = active_dir_q;
   assign phase        = phase_q;
   assign locked       = locked_q;
   assign err_code     = err_code_q;
   assign err_conflict = err_conflict_q;
   assign err_order    = err_order_q;
   assign err_timing   = err_timing_q;
   assign err_sticky   = err_sticky_q;
   assign err_count    = err_count_q;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the four-way light bus driven by the traffic light controller: samples N/S/E/W light codes every clock and decodes them into current direction and phase.
- Flags illegal codes, conflicting greens, wrong phase order and wrong phase durations.
- Used in-system as a safety watchdog and in benches as the scoreboard for the controller.

Parameters:
- GREEN_CYCLES, 16, required length in clocks of every green run.
- YELLOW_CYCLES, 4, required length in clocks of every yellow run.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- N_light  in  3  north light code: 001 green, 010 yellow, 100 red.
- S_light  in  3  south light code, same encoding.
- E_light  in  3  east light code, same encoding.
- W_light  in  3  west light code, same encoding.
- clr_err  in  1  clears err_sticky and err_count.
- active_dir  out  2  decoded non-red direction: 0 N, 1 W, 2 S, 3 E.
- phase  out  1  0 green, 1 yellow.
- locked  out  1  monitor is synchronised to the sequence.
- err_code  out  1  one-cycle pulse on an illegal code or on all-red.
- err_conflict  out  1  one-cycle pulse when two or more directions are non-red.
- err_order  out  1  one-cycle pulse on an illegal phase transition.
- err_timing  out  1  one-cycle pulse on a wrong run length.
- err_sticky  out  1  set by any error.
- err_count  out  8  number of error cycles, saturating at 255.

Behaviour:
- **Reset.** Synchronous, active-high, one clock; highest priority. All outputs, run_len and prev_valid go to 0; FSM goes to SYNC.
- **Sampling and latency.** All outputs are registered. Inputs sampled on edge k are reflected after edge k (one-cycle latency).
- **Decode.**
  - Per direction, any code other than 001, 010 or 100 is illegal.
  - Sample valid = no illegal code and exactly one direction non-red.
  - err_code pulses on any illegal code, or when all four directions are red.
  - err_conflict pulses when ≥2 directions carry a legal non-red code.
  - Both may pulse on the same cycle.
- **Valid sample.** active_dir and phase update. prev_dir, prev_phase and prev_valid=1 are stored.
- **Invalid sample.** active_dir and phase hold. prev_valid=0, locked=0, FSM goes to SYNC, run_len=0.
- **FSM state SYNC.**
  - Only code and conflict checks are active.
  - Lock event: a valid sample with prev_valid=1 and (dir,phase) different from prev.
  - On a lock event: go to LOCKED, locked=1, run_len=1. No order or timing check is applied to the lock event itself.
- **FSM state LOCKED, same (dir,phase) as prev.**
  - run_len increments, saturating at 255.
  - Expected length E = GREEN_CYCLES for green, YELLOW_CYCLES for yellow.
  - When run_len becomes E+1 (overstay), err_timing pulses once. The overstay_flagged bit is set.
- **FSM state LOCKED, (dir,phase) changes.**
  - Legal transitions: (d,green)→(d,yellow) and (d,yellow)→((d+1) mod 4,green). Any other transition pulses err_order.
  - If the finished run had run_len < E (understay), err_timing pulses.
  - No second timing pulse is raised at the change if overstay was already flagged.
  - The new phase starts a fresh run: run_len=1, overstay_flagged=0. FSM stays LOCKED.
- **Error accounting.**
  - Any err_* pulse in a cycle sets err_sticky and adds exactly 1 to err_count, regardless of how many flags fire.
  - clr_err zeroes err_sticky and err_count first. A new error in the same cycle is then applied: sticky=1, count=1.
- **Width rules.** Direction arithmetic is mod 4. Counters are 8 bits and saturate; they never wrap.

Test Plan:
- **Nominal lock.** Reset, then drive N green 16, N yellow 4, W green 16, W yellow 4, S, E and back to N for two full rounds.
  - locked=1 after the edge sampling the first N yellow.
  - active_dir/phase track the inputs with one-cycle lag.
  - No error pulses; err_count=0.
- **Short green.** After lock, drive W green for 15 cycles then W yellow.
  - Single err_timing pulse on the edge sampling W yellow.
  - err_order=0, err_count=1, err_sticky=1.
- **Yellow overstay.** After lock, hold S yellow for 6 cycles then E green.
  - err_timing pulses on the edge sampling the 5th yellow cycle.
  - No pulse at the change; err_count=1.
- **Illegal return.** After lock, drive E yellow for 1 cycle then E green again.
  - err_order and err_timing pulse in the same cycle; err_count increments by exactly 1.
  - locked stays 1.
- **Conflict and illegal code.**
  - Drive N=001, W=001: err_conflict pulses, locked→0.
  - Next drive N=011: err_code pulses.
  - Then restore a nominal sequence: relock at the next phase change; err_count=2.
- **Clear and reset.**
  - Assert clr_err in the same cycle as an err_code input: err_count=1, err_sticky=1.
  - Assert reset mid green: all outputs 0 after that edge, FSM in SYNC.
